subber_arbiter: RTL and testbench
=================================

// Module: subber_arbiter
// PURPOSE
//   Shares a single signed ADDER_WIDTH-bit subtractor among NUM_REQ requesters.
//   Requesters post an operand pair (A, B) with a request line. The block grants
//   one requester at a time in round-robin order and computes A - B on one
//   internal Subber instance. It returns the registered difference with the
//   requester's index, using a valid/ready handshake toward the consumer.
// PARAMETERS
//   ADDER_WIDTH  10  operand/result width, signed two's complement
//   NUM_REQ      4   number of requesters (>=2)
//   ID_W         $clog2(NUM_REQ)  width of res_id (localparam)
// PORTS
//   clk        in   1                    rising-edge clock
//   rst_n      in   1                    asynchronous active-low reset
//   req        in   NUM_REQ              per-requester request; hold until gnt seen
//   a_in       in   NUM_REQ*ADDER_WIDTH  minuends, requester i at [i*W +: W]
//   b_in       in   NUM_REQ*ADDER_WIDTH  subtrahends, same packing
//   gnt        out  NUM_REQ              one-hot, 1-cycle pulse: operands latched
//   result     out  ADDER_WIDTH          signed A - B of served requester
//   res_id     out  ID_W                 index of served requester
//   res_valid  out  1                    result/res_id valid
//   res_ready  in   1                    consumer accepts when res_valid & res_ready
//   busy       out  1                    high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; gnt=0, result=0, res_id=0, res_valid=0,
//     busy=0; RR pointer=0; latched operands cleared. Reset mid-operation
//     drops the in-flight operation silently; no result is produced.
//   FSM states: IDLE, CALC, HOLD. All outputs are registered.
//   IDLE: if |req, choose winner w = first set req scanning ptr, ptr+1, ...
//     (mod NUM_REQ). At the edge, latch a_in/b_in slices of w, gnt<=onehot(w),
//     res_id<=w, go to CALC. If req=0, stay in IDLE.
//   CALC (gnt high this cycle): at the edge, result<=Sum of the shared Subber on
//     the latched operands, res_valid<=1, gnt<=0, go to HOLD.
//   HOLD: result and res_id remain stable while res_valid=1. At the edge with
//     res_ready=1: res_valid<=0, ptr<=(w+1) mod NUM_REQ, go to IDLE.
//     If res_ready=0, stay in HOLD indefinitely.
//   Latency: req seen at edge k -> gnt high in cycle k+1 -> res_valid high in
//     cycle k+2. Minimum 3 cycles per operation with res_ready held at 1. No
//     new grant is issued before the current result is accepted.
//   Arithmetic: result = (A - B) mod 2^ADDER_WIDTH, signed, wrapping. No
//     saturation and no overflow flag.
//   After the latch edge, changes on req, a_in or b_in do not affect the
//     in-flight result. A requester that keeps req high after its gnt pulse is
//     treated as a new request and is served again in its RR turn.
//   res_ready while res_valid=0 is ignored.
//   Fairness: with all req held high, the grant sequence is 0, 1, ...,
//     NUM_REQ-1, 0, ... A continuously requesting index never starves another.
// TESTING
//   1. Reset, req=4'b0001, a0=100, b0=30, res_ready=1 -> gnt=0001 cycle 1;
//      res_valid cycle 2 with result=70, res_id=0; idle afterwards.
//   2. req=4'b1111 held, res_ready=1 -> res_id sequence 0, 1, 2, 3, 0;
//      gnt one-hot and 1 cycle wide each time.
//   3. Wrap: a=-512, b=1 -> result=511. a=511, b=-1 -> result=-512.
//      a=-5, b=-5 -> result=0.
//   4. Backpressure: res_ready=0 for 5 cycles with res_valid high -> result and
//      res_id stable, no gnt pulses; res_ready=1 -> accepted, next grant follows.
//   5. Operands change to a=0, b=0 in the CALC cycle -> result still reflects the
//      latched pair. req dropped during HOLD -> result still delivered.
//   6. rst_n asserted while in HOLD -> all outputs 0 immediately. After release,
//      with req=4'b0110, the first grant goes to index 1 (ptr reset to 0).

Source files
------------

// File: rtl/subber_arbiter.sv
// subber_arbiter: round-robin arbiter that shares one signed subtractor
// among NUM_REQ requesters and returns A - B tagged with the requester index
// over a valid/ready handshake.

// Shared subtractor: wrapping two's-complement difference, no saturation.
module subber #(
  parameter int ADDER_WIDTH = 10
) (
  input  logic signed [ADDER_WIDTH-1:0] a,
  input  logic signed [ADDER_WIDTH-1:0] b,
  output logic signed [ADDER_WIDTH-1:0] sum
);

  assign sum = a - b;

endmodule

module subber_arbiter #(
  parameter int ADDER_WIDTH = 10,
  parameter int NUM_REQ     = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] a_in,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic signed [ADDER_WIDTH-1:0] result,
  output logic [ID_W-1:0]               res_id,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]                   state_p0;
  logic [ID_W-1:0]              ptr;
  logic signed [ADDER_WIDTH-1:0] a_lat_p0;
  logic signed [ADDER_WIDTH-1:0] b_lat_p0;
  logic signed [ADDER_WIDTH-1:0] diff_p1;

  logic                          win_vld;
  logic [ID_W-1:0]               win;
  logic [NUM_REQ-1:0]            win_onehot;
  logic signed [ADDER_WIDTH-1:0] a_sel;
  logic signed [ADDER_WIDTH-1:0] b_sel;
  logic [ID_W-1:0]               ptr_next;
  int                            scan_idx;
  logic [ID_W-1:0]               scan_id;

  // Round-robin scan: first asserted request starting at ptr, wrapping.
  always_comb begin
    win_vld    = 1'b0;
    win        = ptr;
    win_onehot = '0;
    a_sel      = '0;
    b_sel      = '0;
    scan_idx   = 0;
    scan_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_id = ID_W'(scan_idx);
      if (!win_vld && req[scan_id]) begin
        win_vld = 1'b1;
        win     = scan_id;
        a_sel   = $signed(a_in[scan_id*ADDER_WIDTH +: ADDER_WIDTH]);
        b_sel   = $signed(b_in[scan_id*ADDER_WIDTH +: ADDER_WIDTH]);
      end
    end
    win_onehot[win] = win_vld;
  end

  // Pointer moves to the requester just after the one served.
  assign ptr_next = (res_id == ID_W'(NUM_REQ - 1)) ? '0 : res_id + 1'b1;

  subber #(.ADDER_WIDTH(ADDER_WIDTH)) u_subber (
    .a   (a_lat_p0),
    .b   (b_lat_p0),
    .sum (diff_p1)
  );

  // Control FSM: IDLE grants and latches operands, CALC registers the
  // difference, HOLD presents it until the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0  <= IDLE;
      ptr       <= '0;
      a_lat_p0  <= '0;
      b_lat_p0  <= '0;
      gnt       <= '0;
      result    <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_p0)
        // stage p0: operand latch
        IDLE: begin
          if (win_vld) begin
            a_lat_p0 <= a_sel;
            b_lat_p0 <= b_sel;
            gnt      <= win_onehot;
            res_id   <= win;
            busy     <= 1'b1;
            state_p0 <= CALC;
          end
        end
        // stage p1: registered difference
        CALC: begin
          result    <= diff_p1;
          res_valid <= 1'b1;
          gnt       <= '0;
          state_p0  <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ptr       <= ptr_next;
            busy      <= 1'b0;
            state_p0  <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state_p0  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subber_arbiter.sv
// Bench for subber_arbiter: directed operations, expected results queued at
// issue time and compared by a monitor when the DUT hands a result over.
module tb_subber_arbiter;

  localparam int W   = 10;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req;
  logic [N*W-1:0]         a_in;
  logic [N*W-1:0]         b_in;
  logic [N-1:0]           gnt;
  logic signed [W-1:0]    result;
  logic [IDW-1:0]         res_id;
  logic                   res_valid;
  logic                   res_ready;
  logic                   busy;

  typedef struct {
    int res;
    int id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  subber_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .result    (result),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected entry per accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %0d id %0d expected none", result, res_id);
      end else begin
        e = sb.pop_front();
        check("sb_result", int'(result), e.res);
        check("sb_id", int'(res_id), e.id);
      end
    end
    if (rst_n && gnt != '0) check("gnt_onehot", int'($onehot(gnt)), 1);
  end

  task automatic set_ops(input int idx, input int a, input int b);
    a_in[idx*W +: W] = W'(a);
    b_in[idx*W +: W] = W'(b);
  endtask

  task automatic push(input int r, input int id);
    exp_t e;
    e.res = r;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string nm);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt != '0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no gnt expected gnt within 20 cycles", nm);
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(nm, sb.size(), 0);
  endtask

  task automatic do_op(input int idx, input int a, input int b, input int exp, input bit clobber);
    set_ops(idx, a, b);
    req      = '0;
    req[idx] = 1'b1;
    push(exp, idx);
    wait_gnt("op");
    check("op_gnt", int'(gnt), 1 << idx);
    req = '0;
    if (clobber) begin
      a_in = '0;
      b_in = '0;
    end
    drain("op_drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req       = '0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_result", int'(result), 0);
    check("rst_id", int'(res_id), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Single request, latency
    @(negedge clk);
    set_ops(0, 100, 30);
    req = 4'b0001;
    push(70, 0);
    @(negedge clk);
    check("t1_gnt", int'(gnt), 1);
    check("t1_busy", int'(busy), 1);
    check("t1_valid_early", int'(res_valid), 0);
    req = '0;
    @(negedge clk);
    check("t1_valid", int'(res_valid), 1);
    check("t1_gnt_drop", int'(gnt), 0);
    @(negedge clk);
    check("t1_valid_done", int'(res_valid), 0);
    check("t1_busy_done", int'(busy), 0);
    @(negedge clk);
    check("t1_idle_gnt", int'(gnt), 0);
    check("t1_sb_empty", sb.size(), 0);

    // Fresh pointer, then all requesters held high
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(0, 10, 1);
    set_ops(1, 20, 2);
    set_ops(2, 30, 3);
    set_ops(3, 40, 4);
    push(9, 0);
    push(18, 1);
    push(27, 2);
    push(36, 3);
    push(9, 0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("t2");
      check("t2_gnt_seq", int'(gnt), 1 << ord[k]);
      if (k == 4) req = '0;
      @(negedge clk);
      check("t2_gnt_width", int'(gnt), 0);
    end
    drain("t2_drain");

    // Wrapping arithmetic
    do_op(2, -512, 1, 511, 1'b0);
    do_op(3, 511, -1, -512, 1'b0);
    do_op(1, -5, -5, 0, 1'b0);

    // Backpressure
    @(posedge clk);
    #1 res_ready = 1'b0;
    set_ops(2, 200, -50);
    req = 4'b0100;
    push(250, 2);
    wait_gnt("t4");
    check("t4_gnt", int'(gnt), 4);
    req = 4'b1011;
    set_ops(3, 7, 9);
    @(negedge clk);
    check("t4_valid", int'(res_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid", int'(res_valid), 1);
      check("t4_hold_result", int'(result), 250);
      check("t4_hold_id", int'(res_id), 2);
      check("t4_hold_gnt", int'(gnt), 0);
    end
    push(-2, 3);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_gnt("t4_next");
    check("t4_next_gnt", int'(gnt), 8);
    req = '0;
    drain("t4_drain");

    // Operands clobbered in the CALC cycle
    do_op(1, 123, 23, 100, 1'b1);

    // Reset while holding a result
    @(posedge clk);
    #1 res_ready = 1'b0;
    set_ops(2, 5, 2);
    req = 4'b0100;
    wait_gnt("t6");
    check("t6_gnt", int'(gnt), 4);
    req = '0;
    @(negedge clk);
    check("t6_valid", int'(res_valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", int'(gnt), 0);
    check("t6_rst_result", int'(result), 0);
    check("t6_rst_id", int'(res_id), 0);
    check("t6_rst_valid", int'(res_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(1, 50, 8);
    set_ops(2, 1, 1);
    push(42, 1);
    req = 4'b0110;
    wait_gnt("t6_after");
    check("t6_first_gnt", int'(gnt), 2);
    req = '0;
    drain("t6_drain");
    @(negedge clk);
    check("end_busy", int'(busy), 0);
    check("end_valid", int'(res_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
